// File: rtl/stepper_ctrl_if.sv
// Request/limit inputs and coil/status outputs of the jaw stepper controller.
interface stepper_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             open_req;
  logic             close_req;
  logic             half_step;
  logic             limit_open;
  logic             limit_close;
  logic [3:0]       pin;
  logic             jaw_is_open;
  logic             jaw_is_closed;
  logic             busy;
  logic             done;
  logic             fault;
  logic [CNT_W-1:0] step_count;
  logic [2:0]       state;

  modport master (
    output open_req, close_req, half_step, limit_open, limit_close,
    input  pin, jaw_is_open, jaw_is_closed, busy, done, fault, step_count, state
  );

  modport slave (
    input  open_req, close_req, half_step, limit_open, limit_close,
    output pin, jaw_is_open, jaw_is_closed, busy, done, fault, step_count, state
  );
endinterface

// File: rtl/stepper_ctrl.sv
// Jaw stepper controller: prescaled step timing, half/full-step phase sequencing,
// limit-switch handling with a step-count watchdog and a sticky fault state.
module stepper_ctrl #(
  parameter int unsigned CLK_DIV     = 100000,
  parameter int unsigned CLOSE_DIV   = 1,
  parameter int unsigned OPEN_DIV    = 3,
  parameter int unsigned MAX_STEPS   = 400,
  parameter int unsigned HOLD_TORQUE = 1,
  parameter int unsigned CNT_W       = 16
) (
  input logic          clock,
  input logic          resetn,
  stepper_ctrl_if.slave bus
);

  localparam int unsigned PW      = $clog2(CLK_DIV);
  localparam int unsigned DIV_MAX = (CLOSE_DIV > OPEN_DIV) ? CLOSE_DIV : OPEN_DIV;
  localparam int unsigned DW      = $clog2(DIV_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLOSING = 3'd1,
    S_CLOSED  = 3'd2,
    S_OPENING = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q;
  logic [DW-1:0]    div_q, div_d;
  logic [2:0]       phase_q, phase_d;
  logic             half_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [3:0]       pin_q, pin_d;
  logic             done_q, done_d;
  logic             open_q, closed_q, busy_q, fault_q;

  logic             tick, in_motion, strobe, both_lim, at_max, take_step, entry;
  logic [DW-1:0]    div_lim;
  logic [2:0]       amt;

  function automatic logic [3:0] coil(input logic [2:0] p);
    case (p)
      3'd0:    coil = 4'b1000;
      3'd1:    coil = 4'b1100;
      3'd2:    coil = 4'b0100;
      3'd3:    coil = 4'b0110;
      3'd4:    coil = 4'b0010;
      3'd5:    coil = 4'b0011;
      3'd6:    coil = 4'b0001;
      default: coil = 4'b1001;
    endcase
  endfunction

  assign tick      = (presc_q == '0);
  assign in_motion = (state_q == S_CLOSING) || (state_q == S_OPENING);
  assign div_lim   = (state_q == S_CLOSING) ? DW'(CLOSE_DIV - 1) : DW'(OPEN_DIV - 1);
  assign strobe    = in_motion && tick && (div_q == div_lim);
  assign both_lim  = bus.limit_open && bus.limit_close;
  assign at_max    = (count_q == CNT_W'(MAX_STEPS));
  assign amt       = half_q ? 3'd1 : 3'd2;

  // Next-state and datapath; limit switches and the watchdog outrank a pending step.
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    take_step = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (both_lim)                                state_d = S_FAULT;
        else if (bus.open_req)                       state_d = S_IDLE;
        else if (bus.close_req && bus.limit_close) begin
          state_d = S_CLOSED;
          done_d  = 1'b1;
        end
        else if (bus.close_req)                      state_d = S_CLOSING;
      end
      S_CLOSING: begin
        if (both_lim)               state_d = S_FAULT;
        else if (bus.open_req)      state_d = S_OPENING;
        else if (bus.limit_close) begin
          state_d = S_CLOSED;
          done_d  = 1'b1;
        end
        else if (at_max)            state_d = S_FAULT;
        else                        take_step = strobe;
      end
      S_CLOSED: begin
        if (bus.open_req && bus.limit_open) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
        else if (bus.open_req)      state_d = S_OPENING;
      end
      S_OPENING: begin
        if (both_lim)               state_d = S_FAULT;
        else if (bus.limit_open) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
        else if (at_max)            state_d = S_FAULT;
        else                        take_step = strobe;
      end
      default:                      state_d = S_FAULT;
    endcase

    entry = (state_d != state_q) &&
            ((state_d == S_CLOSING) || (state_d == S_OPENING));

    phase_d = phase_q;
    if (take_step) begin
      // Full-step from an even index snaps onto the two-coil phases first.
      if (!half_q && !phase_q[0])      phase_d = phase_q + 3'd1;
      else if (state_q == S_CLOSING)   phase_d = phase_q + amt;
      else                             phase_d = phase_q - amt;
    end

    div_d = div_q;
    if (entry)                 div_d = '0;
    else if (in_motion && tick) div_d = (div_q == div_lim) ? '0 : div_q + DW'(1);

    count_d = count_q;
    if (entry)                                          count_d = '0;
    else if (take_step && (count_q < CNT_W'(MAX_STEPS))) count_d = count_q + CNT_W'(1);

    case (state_d)
      S_CLOSING, S_OPENING: pin_d = coil(phase_d);
      S_CLOSED:             pin_d = (HOLD_TORQUE != 0) ? coil(phase_d) : 4'b0000;
      default:              pin_d = 4'b0000;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      presc_q  <= PW'(CLK_DIV - 1);
      div_q    <= '0;
      phase_q  <= 3'd1;
      half_q   <= 1'b0;
      count_q  <= '0;
      pin_q    <= 4'b0000;
      done_q   <= 1'b0;
      open_q   <= 1'b1;
      closed_q <= 1'b0;
      busy_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= tick ? PW'(CLK_DIV - 1) : presc_q - PW'(1);
      div_q    <= div_d;
      phase_q  <= phase_d;
      if ((state_q == S_IDLE) || (state_q == S_CLOSED)) half_q <= bus.half_step;
      count_q  <= count_d;
      pin_q    <= pin_d;
      done_q   <= done_d;
      open_q   <= (state_d == S_IDLE);
      closed_q <= (state_d == S_CLOSED);
      busy_q   <= (state_d == S_CLOSING) || (state_d == S_OPENING);
      fault_q  <= (state_d == S_FAULT);
    end
  end

  assign bus.pin           = pin_q;
  assign bus.jaw_is_open   = open_q;
  assign bus.jaw_is_closed = closed_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.fault         = fault_q;
  assign bus.step_count    = count_q;
  assign bus.state         = state_q;

endmodule
